// File: rtl/eth_rx_parser.sv
// Receive-side parser for the Ethernet control link: splits MAC byte stream into
// parameter packets (gaze + thresholds) and indexed pixel payload for frame writes.
module eth_rx_parser (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_rx_sof,
  input  logic        i_rx_last,
  input  logic        i_rx_param_flag,
  output logic [10:0] o_gaze_x,
  output logic [10:0] o_gaze_y,
  output logic [23:0] o_tres_1,
  output logic [23:0] o_tres_2,
  output logic [23:0] o_tres_3,
  output logic        o_param_valid,
  output logic [7:0]  o_pix_data,
  output logic        o_pix_valid,
  output logic        o_pix_last,
  output logic [7:0]  o_row_number,
  output logic [14:0] o_pix_index,
  output logic        o_err
);

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned PARAM_BYTES = 12;
  localparam int unsigned SHIFT_W     = (PARAM_BYTES - 1) * BYTE_W;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned LEN_W       = 15;

  typedef enum logic [2:0] {
    IDLE,
    PARAM,
    HDR,
    PAYLOAD,
    DROP
  } state_t;

  // On-wire layout of a parameter packet, MSB first
  typedef struct packed {
    logic        rsvd_x;
    logic [10:0] gaze_x;
    logic        rsvd_y;
    logic [10:0] gaze_y;
    logic [23:0] tres_1;
    logic [23:0] tres_2;
    logic [23:0] tres_3;
  } param_t;

  state_t             state;
  logic [SHIFT_W-1:0] shreg;
  logic [CNT_W-1:0]   cnt;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   idx;

  param_t             pkt;
  logic [LEN_W-1:0]   hdr_len;
  logic               unused_rsvd;

  // Bytes 0..10 live in shreg; the current byte completes the 96-bit view
  assign pkt         = {shreg, i_rx_data};
  assign hdr_len     = {len[LEN_W-1:BYTE_W], i_rx_data};
  assign unused_rsvd = pkt.rsvd_x ^ pkt.rsvd_y;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      shreg         <= '0;
      cnt           <= '0;
      len           <= '0;
      idx           <= '0;
      o_gaze_x      <= '0;
      o_gaze_y      <= '0;
      o_tres_1      <= '0;
      o_tres_2      <= '0;
      o_tres_3      <= '0;
      o_param_valid <= 1'b0;
      o_pix_data    <= '0;
      o_pix_valid   <= 1'b0;
      o_pix_last    <= 1'b0;
      o_row_number  <= '0;
      o_pix_index   <= '0;
      o_err         <= 1'b0;
    end else begin
      o_param_valid <= 1'b0;
      o_pix_valid   <= 1'b0;
      o_pix_last    <= 1'b0;
      o_err         <= 1'b0;

      if (i_rx_valid) begin
        if (i_rx_sof) begin
          // A sof always restarts parsing; an open packet is reported as aborted
          o_err <= (state != IDLE) || i_rx_last;
          cnt   <= CNT_W'(1);
          len   <= '0;
          idx   <= '0;
          if (i_rx_last) begin
            state <= IDLE;
          end else if (i_rx_param_flag) begin
            shreg <= pkt[SHIFT_W-1:0];
            state <= PARAM;
          end else begin
            o_row_number <= i_rx_data;
            state        <= HDR;
          end
        end else begin
          unique case (state)
            IDLE: begin
            end

            PARAM: begin
              shreg <= pkt[SHIFT_W-1:0];
              if (cnt == CNT_W'(PARAM_BYTES - 1)) begin
                if (i_rx_last) begin
                  o_gaze_x      <= pkt.gaze_x;
                  o_gaze_y      <= pkt.gaze_y;
                  o_tres_1      <= pkt.tres_1;
                  o_tres_2      <= pkt.tres_2;
                  o_tres_3      <= pkt.tres_3;
                  o_param_valid <= 1'b1;
                  state         <= IDLE;
                end else begin
                  state <= DROP;
                end
              end else if (i_rx_last) begin
                o_err <= 1'b1;
                state <= IDLE;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end

            HDR: begin
              if (cnt == CNT_W'(1)) begin
                len <= {i_rx_data[BYTE_W-2:0], BYTE_W'(0)};
                cnt <= CNT_W'(2);
                if (i_rx_last) begin
                  o_err <= 1'b1;
                  state <= IDLE;
                end
              end else begin
                len <= hdr_len;
                idx <= '0;
                if (i_rx_last) begin
                  // Zero length ending on byte 2 is a legal empty packet
                  o_err <= (hdr_len != '0);
                  state <= IDLE;
                end else if (hdr_len == '0) begin
                  state <= DROP;
                end else begin
                  state <= PAYLOAD;
                end
              end
            end

            PAYLOAD: begin
              o_pix_data  <= i_rx_data;
              o_pix_valid <= 1'b1;
              o_pix_index <= idx;
              if (idx == len - LEN_W'(1)) begin
                if (i_rx_last) begin
                  o_pix_last <= 1'b1;
                  state      <= IDLE;
                end else begin
                  state <= DROP;
                end
              end else if (i_rx_last) begin
                o_err <= 1'b1;
                state <= IDLE;
              end else begin
                idx <= idx + LEN_W'(1);
              end
            end

            DROP: begin
              if (i_rx_last) begin
                o_err <= 1'b1;
                state <= IDLE;
              end
            end

            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_parser.sv
// Directed bench for eth_rx_parser: vector table for data packets plus
// hand-written parameter, abort and reset sequences.
module tb_eth_rx_parser;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_sof;
  logic        rx_last;
  logic        param_flag;
  logic [10:0] gaze_x;
  logic [10:0] gaze_y;
  logic [23:0] tres_1;
  logic [23:0] tres_2;
  logic [23:0] tres_3;
  logic        param_valid;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_last;
  logic [7:0]  row_number;
  logic [14:0] pix_index;
  logic        err;

  eth_rx_parser dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_rx_data       (rx_data),
    .i_rx_valid      (rx_valid),
    .i_rx_sof        (rx_sof),
    .i_rx_last       (rx_last),
    .i_rx_param_flag (param_flag),
    .o_gaze_x        (gaze_x),
    .o_gaze_y        (gaze_y),
    .o_tres_1        (tres_1),
    .o_tres_2        (tres_2),
    .o_tres_3        (tres_3),
    .o_param_valid   (param_valid),
    .o_pix_data      (pix_data),
    .o_pix_valid     (pix_valid),
    .o_pix_last      (pix_last),
    .o_row_number    (row_number),
    .o_pix_index     (pix_index),
    .o_err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control codes {valid, sof, last, param_flag}
  localparam logic [3:0] GAP   = 4'b0000;
  localparam logic [3:0] D_SOF = 4'b1100;
  localparam logic [3:0] MID   = 4'b1000;
  localparam logic [3:0] LST   = 4'b1010;
  localparam logic [3:0] P_SOF = 4'b1101;
  localparam logic [3:0] P_ONE = 4'b1111;
  // Expected strobes {pix_valid, pix_last, err}
  localparam logic [2:0] NON  = 3'b000;
  localparam logic [2:0] PIX  = 3'b100;
  localparam logic [2:0] PIXL = 3'b110;
  localparam logic [2:0] PIXE = 3'b101;
  localparam logic [2:0] ERR  = 3'b001;

  typedef struct {
    logic [3:0]  ctl;
    logic [7:0]  dat;
    logic [2:0]  strb;
    logic [7:0]  pdat;
    logic [14:0] pidx;
    logic [7:0]  row;
  } vec_t;

  int vectors;
  int miscompares;

  logic [10:0] m_gx;
  logic [10:0] m_gy;
  logic [23:0] m_t1;
  logic [23:0] m_t2;
  logic [23:0] m_t3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      miscompares++;
    end
  endtask

  task automatic drive(input logic [3:0] ctl, input logic [7:0] d);
    @(negedge clk);
    {rx_valid, rx_sof, rx_last, param_flag} = ctl;
    rx_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_params(input string tag);
    chk({tag, " gaze_x"}, 32'(gaze_x), 32'(m_gx));
    chk({tag, " gaze_y"}, 32'(gaze_y), 32'(m_gy));
    chk({tag, " tres_1"}, 32'(tres_1), 32'(m_t1));
    chk({tag, " tres_2"}, 32'(tres_2), 32'(m_t2));
    chk({tag, " tres_3"}, 32'(tres_3), 32'(m_t3));
  endtask

  // Sends a 12-byte parameter packet; term selects whether byte 11 carries last
  task automatic send_param(input logic [95:0] r, input logic term, input logic err0);
    for (int i = 0; i < 12; i++) begin
      logic [3:0] c;
      c = (i == 0) ? P_SOF : ((i == 11 && term) ? 4'b1011 : 4'b1001);
      drive(c, r[8*(11-i) +: 8]);
      if (i == 11 && term) begin
        m_gx = r[94:84];
        m_gy = r[82:72];
        m_t1 = r[71:48];
        m_t2 = r[47:24];
        m_t3 = r[23:0];
      end
      vectors++;
      chk("param_valid", 32'(param_valid), 32'(i == 11 && term));
      chk("param err", 32'(err), 32'((i == 0) ? err0 : 1'b0));
      chk_params("param");
    end
  endtask

  vec_t vecs[$];

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_gx = '0; m_gy = '0; m_t1 = '0; m_t2 = '0; m_t3 = '0;
    rst = 1'b1;
    {rx_valid, rx_sof, rx_last, param_flag} = GAP;
    rx_data = '0;

    // Good data packet, row 5, L=4, gap mid-payload
    vecs.push_back('{D_SOF, 8'h05, NON,  8'h00, 15'd0, 8'h05});
    vecs.push_back('{MID,   8'h00, NON,  8'h00, 15'd0, 8'h05});
    vecs.push_back('{MID,   8'h04, NON,  8'h00, 15'd0, 8'h05});
    vecs.push_back('{MID,   8'h10, PIX,  8'h10, 15'd0, 8'h05});
    vecs.push_back('{GAP,   8'hEE, NON,  8'h00, 15'd0, 8'h05});
    vecs.push_back('{MID,   8'h11, PIX,  8'h11, 15'd1, 8'h05});
    vecs.push_back('{MID,   8'h12, PIX,  8'h12, 15'd2, 8'h05});
    vecs.push_back('{LST,   8'h13, PIXL, 8'h13, 15'd3, 8'h05});
    // Short: L=4, last on second payload byte
    vecs.push_back('{D_SOF, 8'h07, NON,  8'h00, 15'd0, 8'h07});
    vecs.push_back('{MID,   8'h00, NON,  8'h00, 15'd0, 8'h07});
    vecs.push_back('{MID,   8'h04, NON,  8'h00, 15'd0, 8'h07});
    vecs.push_back('{MID,   8'hAA, PIX,  8'hAA, 15'd0, 8'h07});
    vecs.push_back('{LST,   8'hBB, PIXE, 8'hBB, 15'd1, 8'h07});
    vecs.push_back('{MID,   8'h55, NON,  8'h00, 15'd0, 8'h07});
    // Long: L=2, four payload bytes, then back-to-back good packet
    vecs.push_back('{D_SOF, 8'h09, NON,  8'h00, 15'd0, 8'h09});
    vecs.push_back('{MID,   8'h00, NON,  8'h00, 15'd0, 8'h09});
    vecs.push_back('{MID,   8'h02, NON,  8'h00, 15'd0, 8'h09});
    vecs.push_back('{MID,   8'h21, PIX,  8'h21, 15'd0, 8'h09});
    vecs.push_back('{MID,   8'h22, PIX,  8'h22, 15'd1, 8'h09});
    vecs.push_back('{MID,   8'h23, NON,  8'h00, 15'd0, 8'h09});
    vecs.push_back('{LST,   8'h24, ERR,  8'h00, 15'd0, 8'h09});
    vecs.push_back('{D_SOF, 8'h0A, NON,  8'h00, 15'd0, 8'h0A});
    vecs.push_back('{MID,   8'h00, NON,  8'h00, 15'd0, 8'h0A});
    vecs.push_back('{MID,   8'h01, NON,  8'h00, 15'd0, 8'h0A});
    vecs.push_back('{LST,   8'h5A, PIXL, 8'h5A, 15'd0, 8'h0A});
    // Empty packet; length bit 15 set but ignored, so L=0
    vecs.push_back('{D_SOF, 8'h0B, NON,  8'h00, 15'd0, 8'h0B});
    vecs.push_back('{MID,   8'h80, NON,  8'h00, 15'd0, 8'h0B});
    vecs.push_back('{LST,   8'h00, NON,  8'h00, 15'd0, 8'h0B});
    // Header cut short, then single-byte packet
    vecs.push_back('{D_SOF, 8'h0C, NON,  8'h00, 15'd0, 8'h0C});
    vecs.push_back('{LST,   8'h00, ERR,  8'h00, 15'd0, 8'h0C});
    vecs.push_back('{P_ONE, 8'h0D, ERR,  8'h00, 15'd0, 8'h0C});
    // Data packet aborted by sof, replacement parses normally
    vecs.push_back('{D_SOF, 8'h0E, NON,  8'h00, 15'd0, 8'h0E});
    vecs.push_back('{MID,   8'h00, NON,  8'h00, 15'd0, 8'h0E});
    vecs.push_back('{D_SOF, 8'h0F, ERR,  8'h00, 15'd0, 8'h0F});
    vecs.push_back('{MID,   8'h00, NON,  8'h00, 15'd0, 8'h0F});
    vecs.push_back('{MID,   8'h01, NON,  8'h00, 15'd0, 8'h0F});
    vecs.push_back('{LST,   8'h77, PIXL, 8'h77, 15'd0, 8'h0F});
    // L=0 without last drops until last
    vecs.push_back('{D_SOF, 8'h10, NON,  8'h00, 15'd0, 8'h10});
    vecs.push_back('{MID,   8'h00, NON,  8'h00, 15'd0, 8'h10});
    vecs.push_back('{MID,   8'h00, NON,  8'h00, 15'd0, 8'h10});
    vecs.push_back('{MID,   8'h98, NON,  8'h00, 15'd0, 8'h10});
    vecs.push_back('{LST,   8'h99, ERR,  8'h00, 15'd0, 8'h10});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    chk("rst pix_valid", 32'(pix_valid), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst row", 32'(row_number), 32'd0);
    chk("rst pix_index", 32'(pix_index), 32'd0);
    chk("rst param_valid", 32'(param_valid), 32'd0);
    chk_params("rst");
    @(negedge clk);
    rst = 1'b0;

    // Good parameter packet; bit map gives gaze_x = gaze_y = 0x7F8
    send_param(96'h7F8FF8_123456_ABCDEF_000001, 1'b1, 1'b0);
    chk("p1 gaze_x", 32'(gaze_x), 32'h7F8);
    chk("p1 gaze_y", 32'(gaze_y), 32'h7F8);
    chk("p1 tres_1", 32'(tres_1), 32'h123456);
    chk("p1 tres_2", 32'(tres_2), 32'hABCDEF);
    chk("p1 tres_3", 32'(tres_3), 32'h000001);
    drive(GAP, 8'h00);
    vectors++;
    chk("p1 strobe width", 32'(param_valid), 32'd0);
    chk_params("p1 hold");

    // Sof abort after 6 bytes of a parameter packet
    for (int i = 0; i < 6; i++) begin
      drive((i == 0) ? P_SOF : 4'b1001, 8'hC0 + 8'(i));
      vectors++;
      chk("abort pre err", 32'(err), 32'd0);
    end
    send_param(96'h123456_00000A_00000B_00000C, 1'b1, 1'b1);
    chk("p2 gaze_x", 32'(gaze_x), 32'h123);
    chk("p2 gaze_y", 32'(gaze_y), 32'h456);

    // Last on byte 4 of a parameter packet: error, no commit
    for (int i = 0; i < 5; i++) begin
      drive((i == 0) ? P_SOF : ((i == 4) ? 4'b1011 : 4'b1001), 8'hFF);
      vectors++;
      chk("early last err", 32'(err), 32'(i == 4));
      chk("early last pv", 32'(param_valid), 32'd0);
      chk_params("early last");
    end

    // Byte 11 without last: drop, error only at the later last
    send_param(96'hFFFFFF_FFFFFF_FFFFFF_FFFFFF, 1'b0, 1'b0);
    drive(4'b1011, 8'hFF);
    vectors++;
    chk("overlong err", 32'(err), 32'd1);
    chk("overlong pv", 32'(param_valid), 32'd0);
    chk_params("overlong");

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ctl, vecs[i].dat);
      vectors++;
      chk($sformatf("v%0d pix_valid", i), 32'(pix_valid), 32'(vecs[i].strb[2]));
      chk($sformatf("v%0d pix_last", i), 32'(pix_last), 32'(vecs[i].strb[1]));
      chk($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].strb[0]));
      chk($sformatf("v%0d row", i), 32'(row_number), 32'(vecs[i].row));
      chk($sformatf("v%0d param_valid", i), 32'(param_valid), 32'd0);
      if (vecs[i].strb[2]) begin
        chk($sformatf("v%0d pix_data", i), 32'(pix_data), 32'(vecs[i].pdat));
        chk($sformatf("v%0d pix_index", i), 32'(pix_index), 32'(vecs[i].pidx));
      end
    end
    chk_params("after data");

    // Reset in the middle of a payload
    drive(D_SOF, 8'h21);
    drive(MID, 8'h00);
    drive(MID, 8'h03);
    drive(MID, 8'h01);
    vectors++;
    chk("pre-rst pix_valid", 32'(pix_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    drive(MID, 8'h02);
    vectors++;
    chk("mid rst pix_valid", 32'(pix_valid), 32'd0);
    chk("mid rst err", 32'(err), 32'd0);
    chk("mid rst row", 32'(row_number), 32'd0);
    chk("mid rst pix_data", 32'(pix_data), 32'd0);
    m_gx = '0; m_gy = '0; m_t1 = '0; m_t2 = '0; m_t3 = '0;
    chk_params("mid rst");
    @(negedge clk);
    rst = 1'b0;
    drive(MID, 8'h03);
    vectors++;
    chk("post rst idle pix", 32'(pix_valid), 32'd0);
    chk("post rst idle err", 32'(err), 32'd0);
    drive(D_SOF, 8'h22);
    drive(MID, 8'h00);
    drive(MID, 8'h01);
    drive(LST, 8'h44);
    vectors++;
    chk("post rst pix_valid", 32'(pix_valid), 32'd1);
    chk("post rst pix_last", 32'(pix_last), 32'd1);
    chk("post rst pix_data", 32'(pix_data), 32'h44);
    chk("post rst row", 32'(row_number), 32'h22);
    chk("post rst err", 32'(err), 32'd0);

    drive(GAP, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
